psum_collector: RTL and testbench

//   Drain-side counterpart of the PE array: sinks skewed c_out partial sums from the bottom edge
//   of a COLS-wide systolic array, de-skews each column and packs aligned output rows.

---
 rtl/npu_pkg.sv | 15 +
 rtl/psum_fifo.sv | 71 +++++++
 rtl/psum_collector.sv | 163 ++++++++++++++++
 tb/tb_psum_collector.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: default partial-sum width, collector FSM encodings
// and the lane-slice macro used to address one PSUM_W lane of a packed row.
`ifndef NPU_LANE
`define NPU_LANE(j, w) ((j)*(w)) +: (w)
`endif

package npu_pkg;

  localparam int unsigned PSUM_W_DEF = 24;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/psum_fifo.sv
// Single-clock synchronous FIFO for packed psum rows.
// Ports: clk, rst (sync, active-high); push/din write the tail when not full;
//   pop drops the head when not empty; dout = head row; full/empty/count status.
// A push while full is dropped, so push+pop on a full FIFO acts as a pop only.
module psum_fifo
  import npu_pkg::*;
#(
  parameter  int unsigned WIDTH = 96,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned QW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [QW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [QW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pointer/count update; power-of-two depth makes pointers wrap naturally.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    full    = (cnt_q == QW'(DEPTH));
    empty   = (cnt_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + QW'(1);
      2'b01:   cnt_d = cnt_q - QW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/psum_collector.sv
// Drain-side collector for a COLS-wide systolic array: de-skews the bottom-edge
// c_out lanes, packs aligned rows into a FIFO, offers them via valid/ready and
// holds the array while the FIFO is full. Aggregates per-tile error flags.
// Ports: clk, rst (sync, active-high); start/k_len launch a tile; psum_in/err_in
//   from the array; hold back to the array; out_valid/out_ready/out_data row
//   stream; busy, done (one-cycle completion pulse), tile_err (sticky per tile).
// Build option: define PSUM_RELU_EN to clamp negative lanes to 0 on push.
module psum_collector
  import npu_pkg::*;
#(
  parameter  int unsigned COLS   = 4,
  parameter  int unsigned ROWS   = 4,
  parameter  int unsigned PSUM_W = PSUM_W_DEF,
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned CNT_W  = 8,
  localparam int unsigned DW     = COLS * PSUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] k_len,
  input  logic [DW-1:0]    psum_in,
  input  logic [COLS-1:0]  err_in,
  output logic             hold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             busy,
  output logic             done,
  output logic             tile_err
);

  // One spare bit so k_len + COLS + ROWS never wraps.
  localparam int unsigned CTR_W = CNT_W + 1;
  localparam int unsigned QW    = $clog2(DEPTH + 1);

  logic [1:0]        state_q, state_d;
  logic [CTR_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  klen_q, klen_d;
  logic              err_q, err_d;
  logic [PSUM_W-1:0] skew_q [COLS][COLS-1];
  logic [PSUM_W-1:0] skew_d [COLS][COLS-1];
  logic [PSUM_W-1:0] tap    [COLS][COLS];
  logic [PSUM_W-1:0] lane;
  logic [CTR_W-1:0]  row_lo, row_hi, col_lo;
  logic [COLS-1:0]   err_win;
  logic [DW-1:0]     row;
  logic              push;
  logic              fifo_full, fifo_empty;
  logic [QW-1:0]     fifo_count;

  // tap[j][s] = lane j delayed by s advancing cycles.
  always_comb begin
    for (int j = 0; j < COLS; j++) begin
      tap[j][0] = psum_in[`NPU_LANE(j, PSUM_W)];
      for (int s = 1; s < COLS; s++) begin
        tap[j][s] = skew_q[j][s-1];
      end
    end
  end

  // Next-state, alignment, push and error accumulation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    err_d   = err_q;
    skew_d  = skew_q;
    push    = 1'b0;
    row     = '0;
    lane    = '0;
    col_lo  = '0;
    err_win = '0;
    row_lo  = CTR_W'(klen_q) + CTR_W'(COLS - 1);
    row_hi  = row_lo + CTR_W'(ROWS - 1);

    for (int j = 0; j < COLS; j++) begin
      lane = tap[j][COLS-1-j];
`ifdef PSUM_RELU_EN
      if (lane[PSUM_W-1]) begin
        lane = '0;
      end
`endif
      row[`NPU_LANE(j, PSUM_W)] = lane;
      // Column j carries tile data for counter in [k_len+j, k_len+j+ROWS-1].
      col_lo     = CTR_W'(klen_q) + CTR_W'(j);
      err_win[j] = err_in[j] && (cnt_q >= col_lo) && (cnt_q <= col_lo + CTR_W'(ROWS - 1));
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          klen_d  = (k_len == '0) ? CNT_W'(1) : k_len;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        // Everything freezes with the array while the FIFO is full.
        if (!fifo_full) begin
          cnt_d = cnt_q + CTR_W'(1);
          err_d = err_q | (|err_win);
          for (int j = 0; j < COLS; j++) begin
            for (int s = 0; s < COLS - 1; s++) begin
              skew_d[j][s] = tap[j][s];
            end
          end
          if ((cnt_q >= row_lo) && (cnt_q <= row_hi)) begin
            push = 1'b1;
            if (cnt_q == row_hi) begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      klen_q  <= '0;
      err_q   <= 1'b0;
      skew_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      klen_q  <= klen_d;
      err_q   <= err_d;
      skew_q  <= skew_d;
    end
  end

  psum_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (row),
    .pop   (out_ready),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign hold      = fifo_full;
  assign out_valid = (fifo_count != '0);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DRAIN) && fifo_empty;
  assign tile_err  = err_q;

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: models the skewed array drain (frozen by
// hold), checks popped rows against hand-chosen lane tables and timing/status.
module tb_psum_collector;

  localparam int unsigned COLS  = 4;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned PW    = 24;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DW    = COLS * PW;

  logic             clk = 1'b0;
  logic             rst, start, out_ready;
  logic [CNT_W-1:0] k_len;
  logic [DW-1:0]    psum_in, out_data;
  logic [COLS-1:0]  err_in;
  logic             hold, out_valid, busy, done, tile_err;

  always #5 clk = ~clk;

  psum_collector #(
    .COLS(COLS), .ROWS(ROWS), .PSUM_W(PW), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .psum_in(psum_in),
    .err_in(err_in), .hold(hold), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done), .tile_err(tile_err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int lane_val [COLS][ROWS];
  int kk = 0, tc = 0, cyc = 0;
  int first_valid = -1, done_cyc = -1, hold_cyc = -1, pop_idx = 0;
  int err_tc = -1;
  logic [COLS-1:0] err_mask = '0;
  bit arr_run = 1'b0;
  logic done_err = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // mode 0: lane j row r = 100*j+r ; mode 1: signed lanes
  task automatic set_data(input int mode);
    for (int j = 0; j < COLS; j++)
      for (int r = 0; r < ROWS; r++)
        lane_val[j][r] = 100 * j + r;
    if (mode == 1) begin
      for (int r = 0; r < ROWS; r++) begin
        lane_val[0][r] = -43;
        lane_val[1][r] = -5655;
        lane_val[2][r] = -1;
        lane_val[3][r] = 1000 + r;
      end
    end
  endtask

  function automatic logic [DW-1:0] exp_row(input int r);
    logic [DW-1:0] v;
    int x;
    v = '0;
    for (int j = 0; j < COLS; j++) begin
      x = lane_val[j][r];
`ifdef PSUM_RELU_EN
      if (x < 0) x = 0;
`endif
      v[j*PW +: PW] = PW'(x);
    end
    return v;
  endfunction

  // Array model: lane j shows row tc-kk-j inside its window, filler elsewhere.
  task automatic drive_inputs();
    int r;
    for (int j = 0; j < COLS; j++) begin
      r = tc - kk - j;
      if (arr_run && r >= 0 && r < int'(ROWS)) psum_in[j*PW +: PW] = PW'(lane_val[j][r]);
      else psum_in[j*PW +: PW] = 24'h5A5A5A;
    end
    err_in = (arr_run && tc == err_tc) ? err_mask : '0;
  endtask

  task automatic step();
    logic h;
    h = hold;
    if (out_valid && out_ready) begin
      if (pop_idx < int'(ROWS)) check($sformatf("row%0d", pop_idx), out_data, exp_row(pop_idx));
      else check("extra_pop", DW'(1), DW'(0));
      pop_idx++;
    end
    @(posedge clk);
    #1;
    if (arr_run && !h) tc++;
    cyc++;
    drive_inputs();
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (hold && hold_cyc < 0) hold_cyc = cyc;
    if (done && done_cyc < 0) begin
      done_cyc = cyc;
      done_err = tile_err;
    end
  endtask

  task automatic do_start(input int k, input int keff);
    k_len = CNT_W'(k);
    start = 1'b1;
    step();
    start = 1'b0;
    kk = keff;
    tc = 0;
    arr_run = 1'b1;
    cyc = 0;
    first_valid = -1;
    done_cyc = -1;
    hold_cyc = -1;
    pop_idx = 0;
    drive_inputs();
  endtask

  task automatic finish_tile(input int exp_fv, input int exp_dc, input logic exp_err);
    int n;
    n = 0;
    while (done_cyc < 0 && n < 60) begin
      step();
      n++;
    end
    check("done_seen", DW'(done_cyc >= 0), DW'(1));
    check("first_valid_cyc", DW'(first_valid), DW'(exp_fv));
    check("done_cyc", DW'(done_cyc), DW'(exp_dc));
    check("rows_popped", DW'(pop_idx), DW'(ROWS));
    check("tile_err_at_done", DW'(done_err), DW'(exp_err));
    step();
    check("idle_after_done", DW'({busy, done}), DW'(0));
    arr_run = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; out_ready = 1'b0;
    psum_in = '0; err_in = '0;
    set_data(0);
    step(); step();
    rst = 1'b0;
    check("rst_hold", DW'(hold), DW'(0));
    check("rst_valid", DW'(out_valid), DW'(0));
    check("rst_busy_done_err", DW'({busy, done, tile_err}), DW'(0));
    check("rst_data", out_data, DW'(0));

    // Reset mid-RUN with two rows buffered
    do_start(3, 3);
    while (cyc < 8) step();
    check("pre_rst_valid", DW'(out_valid), DW'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    arr_run = 1'b0;
    check("midrst_busy", DW'(busy), DW'(0));
    check("midrst_valid", DW'(out_valid), DW'(0));
    check("midrst_hold", DW'(hold), DW'(0));
    check("midrst_data", out_data, DW'(0));
    step();
    check("midrst_valid_after", DW'(out_valid), DW'(0));

    // Nominal k_len=3, with an ignored start while busy
    out_ready = 1'b1;
    do_start(3, 3);
    step(); step(); step();
    start = 1'b1; k_len = '0;
    step();
    start = 1'b0;
    finish_tile(7, 11, 1'b0);

    // Backpressure: FIFO fills, then drains in order
    out_ready = 1'b0;
    do_start(3, 3);
    while (cyc < 12) step();
    check("bp_hold_cyc", DW'(hold_cyc), DW'(10));
    check("bp_hold", DW'(hold), DW'(1));
    check("bp_valid_busy", DW'({out_valid, busy, done}), DW'(3'b110));
    out_ready = 1'b1;
    finish_tile(7, 16, 1'b0);

    // Push+pop with count=DEPTH-1 keeps hold low
    out_ready = 1'b0;
    do_start(3, 3);
    while (cyc < 9) step();
    check("pp_hold_before", DW'(hold), DW'(0));
    out_ready = 1'b1;
    step();
    check("pp_hold_after", DW'(hold), DW'(0));
    check("pp_valid", DW'(out_valid), DW'(1));
    finish_tile(7, 13, 1'b0);
    check("pp_never_full", DW'(hold_cyc), DW'(-1));

    // Signed lanes
    set_data(1);
    do_start(2, 2);
    finish_tile(6, 10, 1'b0);

    // Error aggregation: column 2 in its window, then a clean tile
    set_data(0);
    err_tc = 6; err_mask = 4'b0100;
    do_start(3, 3);
    finish_tile(7, 11, 1'b1);
    check("err_sticky_idle", DW'(tile_err), DW'(1));
    err_tc = 0; err_mask = 4'b1000;
    do_start(3, 3);
    check("err_cleared_on_start", DW'(tile_err), DW'(0));
    finish_tile(7, 11, 1'b0);
    err_tc = -1; err_mask = '0;

    // k_len=0 behaves as k_len=1
    do_start(0, 1);
    finish_tile(5, 9, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
